sodor5_verif: RTL and testbench
===============================

# sodor5_verif

Golden architectural reference model and lockstep checker for the Sodor 5-stage RV32I core. It consumes the same instruction stream fed to the core, one instruction per cycle. It executes the OP-IMM, LOAD and STORE subset against its own 32×32 register file and 16-word data memory. It compares its pipeline-aligned writeback stream against the core's retirement port and raises a sticky mismatch flag.

## Interface
- `WB_LAT`, default 4: cycles from instruction sample to model writeback output, matching the 5-stage core.
- `DMEM_WORDS`, default 16: data-memory depth in 32-bit words (power of two).
- `clk` input 1: sole clock, rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `instr` input 32: instruction fetched this cycle.
- `core_wb_valid` input 1: core retired a register write this cycle.
- `core_wb_rd` input 5: core destination register.
- `core_wb_data` input 32: core write data.
- `wb_valid` output 1: model writeback valid, non-x0 destinations only.
- `wb_rd` output 5: model destination register.
- `wb_data` output 32: model write data.
- `mem_we` output 1: model store strobe, same alignment as `wb_valid`.
- `mem_addr` output 32: model store byte address.
- `mem_wdata` output 32: model store data, lane-aligned.
- `mismatch` output 1: sticky compare failure.
- `mismatch_cnt` output 16: number of mismatching cycles, saturating at 0xFFFF.

## Operation
- Reset (`reset_n`=0):
  - All outputs go to 0; the delay line is cleared.
  - Register file is cleared to 0.
  - `dmem[i]` is set to `i*32'h11111111`, for i = 0..15.
  - `instr` is ignored while reset is asserted.
- Each rising edge out of reset decodes `instr[6:0]`.
- `0010011` OP-IMM, with imm = sign-extended `instr[31:20]`:
  - funct3 0 ADDI, 2 SLTI (signed), 3 SLTIU (unsigned compare of sign-extended imm), 4 XORI, 6 ORI, 7 ANDI.
  - funct3 1 SLLI, shamt = `imm[4:0]`.
  - funct3 5: SRAI if `instr[30]`=1, else SRLI.
- `0000011` LOAD, address = rs1 + sext(`instr[31:20]`):
  - Word index = `addr[5:2]`, wrapping modulo `DMEM_WORDS`.
  - funct3 0 LB and 4 LBU select byte lane `addr[1:0]`, with sign or zero extension respectively.
  - funct3 1 LH and 5 LHU select half-word `addr[1]`.
  - funct3 2 LW ignores `addr[1:0]`.
- `0100011` STORE, address = rs1 + sext({`instr[31:25]`, `instr[11:7]`}):
  - funct3 0 SB and 1 SH write only the addressed lanes of rs2.
  - funct3 2 SW writes the whole word.
- Every other opcode or funct3 is a NOP: no state change, no writeback.
- x0 always reads 0. Writes to rd=0 update nothing and produce `wb_valid`=0.
- Architectural state updates at the sampling edge. The next instruction observes the result, so the model has no hazards.
- Compare: on any cycle where `wb_valid`≠`core_wb_valid`, or both are 1 and (`wb_rd`,`wb_data`)≠(`core_wb_rd`,`core_wb_data`):
  - `mismatch` is set and held until reset.
  - `mismatch_cnt` increments.

## Timing
- An instruction sampled at edge N appears on `wb_*` and `mem_*` after edge N+`WB_LAT`, through a `WB_LAT`-deep register delay line.
- Compare is registered: `mismatch` rises one cycle after the offending cycle.
- Back-to-back instructions are accepted every cycle without stall. A store at N is visible to a load at N+1.
- Reset asserted mid-stream flushes in-flight writebacks immediately; none are emitted after release.
- A load whose address exceeds the memory depth wraps; it is not an error.

## Structure
- Shared package `sodor5_pkg`:
  - opcode constants (`OPC_OPIMM`, `OPC_LOAD`, `OPC_STORE`) and funct3 encodings;
  - the `wb_pkt_t` struct {valid, rd, data, we, addr, wdata};
  - the `NOP` = 32'h00000013 constant.
- One sub-module, `sodor5_arch_dmem`: byte-lane writable word memory with reset initialisation pattern and combinational read.
- Register file, ALU, decode, delay line and checker stay in the top block.

## Test plan
- Release reset, drive ADDI x1,x0,5 → 4 cycles later `wb_valid`=1, `wb_rd`=1, `wb_data`=0x00000005, `mismatch`=0 when the core port matches.
- LB x2,4(x0) then LBU x3,7(x0) → writebacks 0x00000011 and 0x00000011.
- ADDI x4,x0,-1; SB x4,8(x0); LB x5,8(x0); LW x6,8(x0):
  - x5 = 0xFFFFFFFF;
  - x6 = 0x222222FF;
  - store cycle shows `mem_we`=1, `mem_addr`=8, lane-0 data 0xFF.
- LUI-free shift check, x7 = 0x80000000 via SLLI from x=1 by 31:
  - SRAI x8,x7,4 → 0xF8000000;
  - SRLI x9,x7,4 → 0x08000000;
  - SLTIU x10,x0,-1 → 1.
- ADDI x0,x0,7 and an unknown opcode 0x0000007F → `wb_valid`=0 both slots; x0 still reads 0.
- Drive `core_wb_data` wrong by one bit on one retirement:
  - `mismatch`=1 next cycle, `mismatch_cnt`=1;
  - both hold through later correct retirements;
  - assert `reset_n`=0 mid-stream → both clear and memory returns to the 0x11111111×i pattern.

Source files
------------

// File: rtl/sodor5_pkg.sv
// sodor5_pkg: shared definitions for the Sodor 5-stage golden reference checker.
// Contents: RV32I opcode/funct3 constants for the OP-IMM, LOAD and STORE subset,
// the canonical NOP encoding, and the writeback/store packet carried down the delay line.
package sodor5_pkg;

  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // OP-IMM funct3
  localparam logic [2:0] F3_ADDI  = 3'd0;
  localparam logic [2:0] F3_SLLI  = 3'd1;
  localparam logic [2:0] F3_SLTI  = 3'd2;
  localparam logic [2:0] F3_SLTIU = 3'd3;
  localparam logic [2:0] F3_XORI  = 3'd4;
  localparam logic [2:0] F3_SRXI  = 3'd5;  // SRLI / SRAI, split by instr[30]
  localparam logic [2:0] F3_ORI   = 3'd6;
  localparam logic [2:0] F3_ANDI  = 3'd7;

  // LOAD funct3
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  // STORE funct3
  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } wb_pkt_t;

endpackage

// File: rtl/sodor5_arch_dmem.sv
// sodor5_arch_dmem: architectural data memory of the reference model.
// Byte-lane writable words, combinational read, reset loads word i with i*0x11111111.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   we_i, widx_i         write enable and word index
//   wstrb_i, wdata_i     byte-lane strobes and lane-aligned write data
//   ridx_i, rdata_o      read word index and combinational read data
module sodor5_arch_dmem
  import sodor5_pkg::*;
#(
  parameter int unsigned Words = 16,
  localparam int unsigned IdxW = $clog2(Words)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            we_i,
  input  logic [IdxW-1:0] widx_i,
  input  logic [3:0]      wstrb_i,
  input  logic [31:0]     wdata_i,
  input  logic [IdxW-1:0] ridx_i,
  output logic [31:0]     rdata_o
);

  logic [31:0] mem_q [Words];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Words; i++) begin
        mem_q[i] <= i * 32'h11111111;
      end
    end else if (we_i) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb_i[b]) begin
          mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/sodor5_verif.sv
// sodor5_verif: golden RV32I (OP-IMM/LOAD/STORE) reference model and lockstep checker.
// Executes one instruction per cycle against its own register file and data memory,
// delays the resulting writeback/store packet to line up with the core's retirement
// port, and flags any disagreement with a sticky bit plus a saturating counter.
// Ports:
//   clk, reset_n                               clock, asynchronous active-low reset
//   instr                                      instruction fetched this cycle
//   core_wb_valid/core_wb_rd/core_wb_data      core retirement port
//   wb_valid/wb_rd/wb_data                     model writeback (non-x0 only)
//   mem_we/mem_addr/mem_wdata                  model store, lane-aligned data
//   mismatch, mismatch_cnt                     sticky flag, saturating mismatch count
module sodor5_verif
  import sodor5_pkg::*;
#(
  parameter int unsigned WB_LAT     = 4,
  parameter int unsigned DMEM_WORDS = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr,
  input  logic        core_wb_valid,
  input  logic [4:0]  core_wb_rd,
  input  logic [31:0] core_wb_data,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mismatch,
  output logic [15:0] mismatch_cnt
);

  localparam int unsigned IdxW = $clog2(DMEM_WORDS);

  // Decode
  logic [6:0]  opc;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2, shamt;
  logic [31:0] imm_i, imm_s, rs1_val, rs2_val, eff_addr, sra_res;

  assign opc    = instr[6:0];
  assign funct3 = instr[14:12];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign shamt  = imm_i[4:0];

  // Register file; entry 0 is never written, so it always reads zero.
  logic [31:0] rf_q [32];

  assign rs1_val  = rf_q[rs1];
  assign rs2_val  = rf_q[rs2];
  assign eff_addr = rs1_val + ((opc == OPC_STORE) ? imm_s : imm_i);
  assign sra_res  = $signed(rs1_val) >>> shamt;

  // Data memory and load lane selection
  logic [31:0] ld_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        st_en;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;

  sodor5_arch_dmem #(
    .Words(DMEM_WORDS)
  ) u_dmem (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .we_i   (st_en),
    .widx_i (eff_addr[IdxW+1:2]),
    .wstrb_i(st_strb),
    .wdata_i(st_wdata),
    .ridx_i (eff_addr[IdxW+1:2]),
    .rdata_o(ld_word)
  );

  always_comb begin
    ld_byte = ld_word[7:0];
    unique case (eff_addr[1:0])
      2'd0: ld_byte = ld_word[7:0];
      2'd1: ld_byte = ld_word[15:8];
      2'd2: ld_byte = ld_word[23:16];
      2'd3: ld_byte = ld_word[31:24];
    endcase
  end

  assign ld_half = eff_addr[1] ? ld_word[31:16] : ld_word[15:0];

  // Execute
  logic        wr_en, wr_valid;
  logic [31:0] wr_res;

  always_comb begin
    wr_en    = 1'b0;
    wr_res   = '0;
    st_en    = 1'b0;
    st_strb  = '0;
    st_wdata = '0;
    case (opc)
      OPC_OPIMM: begin
        wr_en = 1'b1;
        unique case (funct3)
          F3_ADDI:  wr_res = rs1_val + imm_i;
          F3_SLLI:  wr_res = rs1_val << shamt;
          F3_SLTI:  wr_res = {31'd0, $signed(rs1_val) < $signed(imm_i)};
          F3_SLTIU: wr_res = {31'd0, rs1_val < imm_i};
          F3_XORI:  wr_res = rs1_val ^ imm_i;
          F3_SRXI:  wr_res = instr[30] ? sra_res : (rs1_val >> shamt);
          F3_ORI:   wr_res = rs1_val | imm_i;
          F3_ANDI:  wr_res = rs1_val & imm_i;
        endcase
      end
      OPC_LOAD: begin
        wr_en = 1'b1;
        case (funct3)
          F3_LB:   wr_res = {{24{ld_byte[7]}}, ld_byte};
          F3_LH:   wr_res = {{16{ld_half[15]}}, ld_half};
          F3_LW:   wr_res = ld_word;
          F3_LBU:  wr_res = {24'd0, ld_byte};
          F3_LHU:  wr_res = {16'd0, ld_half};
          default: wr_en  = 1'b0;
        endcase
      end
      OPC_STORE: begin
        st_en = 1'b1;
        case (funct3)
          F3_SB: begin
            st_strb  = 4'b0001 << eff_addr[1:0];
            st_wdata = {24'd0, rs2_val[7:0]} << {eff_addr[1:0], 3'b000};
          end
          F3_SH: begin
            st_strb  = eff_addr[1] ? 4'b1100 : 4'b0011;
            st_wdata = eff_addr[1] ? {rs2_val[15:0], 16'd0} : {16'd0, rs2_val[15:0]};
          end
          F3_SW: begin
            st_strb  = 4'b1111;
            st_wdata = rs2_val;
          end
          default: st_en = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  assign wr_valid = wr_en && (rd != 5'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wr_valid) begin
      rf_q[rd] <= wr_res;
    end
  end

  // Packet fields not relevant to the instruction are forced to zero.
  wb_pkt_t pkt_d;

  always_comb begin
    pkt_d       = '0;
    pkt_d.valid = wr_valid;
    pkt_d.we    = st_en;
    if (wr_valid) begin
      pkt_d.rd   = rd;
      pkt_d.data = wr_res;
    end
    if (st_en) begin
      pkt_d.addr  = eff_addr;
      pkt_d.wdata = st_wdata;
    end
  end

  // Stage 0 captures the packet at the sampling edge; WB_LAT further stages align it
  // with the core's retirement so it appears after edge N+WB_LAT.
  wb_pkt_t pipe_q [WB_LAT+1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i <= WB_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= pkt_d;
      for (int unsigned i = 1; i <= WB_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign wb_valid  = pipe_q[WB_LAT].valid;
  assign wb_rd     = pipe_q[WB_LAT].rd;
  assign wb_data   = pipe_q[WB_LAT].data;
  assign mem_we    = pipe_q[WB_LAT].we;
  assign mem_addr  = pipe_q[WB_LAT].addr;
  assign mem_wdata = pipe_q[WB_LAT].wdata;

  // Lockstep compare
  logic        diff;
  logic        mismatch_q, mismatch_d;
  logic [15:0] cnt_q, cnt_d;

  assign diff = (wb_valid != core_wb_valid) ||
                (wb_valid && core_wb_valid &&
                 ((wb_rd != core_wb_rd) || (wb_data != core_wb_data)));

  always_comb begin
    mismatch_d = mismatch_q | diff;
    cnt_d      = cnt_q;
    if (diff && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mismatch_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mismatch     = mismatch_q;
  assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_sodor5_verif.sv
module tb_sodor5_verif;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr;
  logic        core_wb_valid;
  logic [4:0]  core_wb_rd;
  logic [31:0] core_wb_data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mismatch;
  logic [15:0] mismatch_cnt;

  always #5 clk = ~clk;

  sodor5_verif #(
    .WB_LAT    (LAT),
    .DMEM_WORDS(16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr        (instr),
    .core_wb_valid(core_wb_valid),
    .core_wb_rd   (core_wb_rd),
    .core_wb_data (core_wb_data),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mismatch     (mismatch),
    .mismatch_cnt (mismatch_cnt)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  // Reference state: architectural registers and a byte-addressed memory image.
  logic [31:0] regs [32];
  logic [7:0]  mem_b [64];
  exp_t        expq [$];
  logic        m_flag;
  logic [15:0] m_cnt;
  bit          flip_pending;
  logic [31:0] dut_last [32];
  logic        st_seen;
  logic [31:0] st_addr, st_wdata;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  task automatic model_reset();
    exp_t z;
    z = '{default: '0};
    for (int i = 0; i < 32; i++) regs[i] = '0;
    for (int i = 0; i < 64; i++) mem_b[i] = 8'((i / 4) * 8'h11);
    for (int i = 0; i < 32; i++) dut_last[i] = 'x;
    expq.delete();
    for (int i = 0; i <= LAT; i++) expq.push_back(z);
    m_flag = 1'b0;
    m_cnt = '0;
    st_seen = 1'b0;
  endtask

  task automatic model_exec(input logic [31:0] ins, output exp_t p);
    logic [31:0] a, b, immi, imms, ea, r;
    logic [5:0]  lo;
    logic        wr;
    p = '{default: '0};
    a = regs[ins[19:15]];
    b = regs[ins[24:20]];
    immi = {{20{ins[31]}}, ins[31:20]};
    imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    wr = 1'b0;
    r = '0;
    if (ins[6:0] == 7'h13) begin
      wr = 1'b1;
      case (ins[14:12])
        3'd0: r = a + immi;
        3'd1: r = a << immi[4:0];
        3'd2: r = ($signed(a) < $signed(immi)) ? 32'd1 : 32'd0;
        3'd3: r = (a < immi) ? 32'd1 : 32'd0;
        3'd4: r = a ^ immi;
        3'd5: begin
          if (ins[30]) r = $signed(a) >>> immi[4:0];
          else r = a >> immi[4:0];
        end
        3'd6: r = a | immi;
        default: r = a & immi;
      endcase
    end else if (ins[6:0] == 7'h03) begin
      ea = a + immi;
      lo = ea[5:0];
      wr = 1'b1;
      case (ins[14:12])
        3'd0: r = {{24{mem_b[lo][7]}}, mem_b[lo]};
        3'd4: r = {24'd0, mem_b[lo]};
        3'd1, 3'd5: begin
          r = {16'd0, mem_b[{lo[5:1], 1'b1}], mem_b[{lo[5:1], 1'b0}]};
          if (ins[14:12] == 3'd1 && r[15]) r[31:16] = 16'hFFFF;
        end
        3'd2: r = {mem_b[{lo[5:2], 2'd3}], mem_b[{lo[5:2], 2'd2}],
                   mem_b[{lo[5:2], 2'd1}], mem_b[{lo[5:2], 2'd0}]};
        default: wr = 1'b0;
      endcase
    end else if (ins[6:0] == 7'h23 && ins[14:12] <= 3'd2) begin
      int nb, first;
      ea = a + imms;
      lo = ea[5:0];
      nb = 1 << ins[14:12];
      first = int'(lo) & ~(nb - 1);
      p.we = 1'b1;
      p.addr = ea;
      p.wdata = '0;
      for (int k = 0; k < nb; k++) begin
        mem_b[first + k] = b[8*k +: 8];
        p.wdata[8*((first + k) % 4) +: 8] = b[8*k +: 8];
      end
    end
    if (wr && ins[11:7] != 5'd0) begin
      regs[ins[11:7]] = r;
      p.valid = 1'b1;
      p.rd = ins[11:7];
      p.data = r;
    end
  endtask

  task automatic step(input logic [31:0] ins);
    exp_t cur, nxt;
    logic [31:0] cd;
    bit hit;
    cur = expq[0];
    cd = cur.data;
    hit = 1'b0;
    if (flip_pending && cur.valid) begin
      cd ^= 32'h0000_0100;
      flip_pending = 1'b0;
      hit = 1'b1;
    end
    instr = ins;
    core_wb_valid = cur.valid;
    core_wb_rd = cur.rd;
    core_wb_data = cd;
    @(negedge clk);
    chk("wb_valid", wb_valid, cur.valid);
    if (cur.valid) begin
      chk("wb_rd", wb_rd, cur.rd);
      chk("wb_data", wb_data, cur.data);
    end
    chk("mem_we", mem_we, cur.we);
    if (cur.we) begin
      chk("mem_addr", mem_addr, cur.addr);
      chk("mem_wdata", mem_wdata, cur.wdata);
    end
    chk("mismatch", mismatch, m_flag);
    chk("mismatch_cnt", mismatch_cnt, m_cnt);
    if (wb_valid === 1'b1) dut_last[wb_rd] = wb_data;
    if (mem_we === 1'b1) begin
      st_seen = 1'b1;
      st_addr = mem_addr;
      st_wdata = mem_wdata;
    end
    @(posedge clk);
    if (hit) begin
      m_flag = 1'b1;
      m_cnt++;
    end
    model_exec(ins, nxt);
    expq.push_back(nxt);
    void'(expq.pop_front());
    #1;
  endtask

  task automatic pad(input int n);
    for (int i = 0; i < n; i++) step(32'h00000013);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    instr = $urandom;
    core_wb_valid = 1'b0;
    core_wb_rd = '0;
    core_wb_data = '0;
    #1;
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mismatch", mismatch, 1'b0);
    chk("rst_mismatch_cnt", mismatch_cnt, 16'd0);
    repeat (2) @(posedge clk);
    instr = $urandom;
    #1;
    chk("rst_wb_data", wb_data, 32'd0);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] ins;
    int sel;
    reset_n = 1'b0;
    instr = '0;
    core_wb_valid = 1'b0;
    core_wb_rd = '0;
    core_wb_data = '0;
    flip_pending = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // ADDI x1,x0,5 retires four cycles later
    step(enc_i(7'h13, 3'd0, 5'd1, 5'd0, 12'd5));
    pad(4);
    chk("addi_valid", wb_valid, 1'b1);
    chk("addi_rd", wb_rd, 5'd1);
    chk("addi_data", wb_data, 32'h5);
    chk("addi_mismatch", mismatch, 1'b0);

    // Byte loads from the reset pattern
    step(enc_i(7'h03, 3'd0, 5'd2, 5'd0, 12'd4));
    step(enc_i(7'h03, 3'd4, 5'd3, 5'd0, 12'd7));
    pad(5);
    chk("lb_x2", dut_last[2], 32'h00000011);
    chk("lbu_x3", dut_last[3], 32'h00000011);

    // Store byte then read back signed byte and full word
    step(enc_i(7'h13, 3'd0, 5'd4, 5'd0, 12'hFFF));
    step(enc_s(3'd0, 5'd0, 5'd4, 12'd8));
    step(enc_i(7'h03, 3'd0, 5'd5, 5'd0, 12'd8));
    step(enc_i(7'h03, 3'd2, 5'd6, 5'd0, 12'd8));
    pad(5);
    chk("lb_x5", dut_last[5], 32'hFFFFFFFF);
    chk("lw_x6", dut_last[6], 32'h222222FF);
    chk("sb_seen", st_seen, 1'b1);
    chk("sb_addr", st_addr, 32'd8);
    chk("sb_lane0", {24'd0, st_wdata[7:0]}, 32'hFF);

    // Shifts and unsigned compare
    step(enc_i(7'h13, 3'd0, 5'd7, 5'd0, 12'd1));
    step(enc_i(7'h13, 3'd1, 5'd7, 5'd7, 12'd31));
    step(enc_i(7'h13, 3'd5, 5'd8, 5'd7, 12'h404));
    step(enc_i(7'h13, 3'd5, 5'd9, 5'd7, 12'd4));
    step(enc_i(7'h13, 3'd3, 5'd10, 5'd0, 12'hFFF));
    pad(5);
    chk("slli_x7", dut_last[7], 32'h80000000);
    chk("srai_x8", dut_last[8], 32'hF8000000);
    chk("srli_x9", dut_last[9], 32'h08000000);
    chk("sltiu_x10", dut_last[10], 32'h1);

    // x0 writes and unknown opcode produce nothing
    step(enc_i(7'h13, 3'd0, 5'd0, 5'd0, 12'd7));
    step(32'h0000007F);
    step(enc_i(7'h13, 3'd6, 5'd12, 5'd0, 12'h010));
    pad(5);
    chk("x0_never_written", dut_last[0], 'x);
    chk("ori_x12", dut_last[12], 32'h10);

    // One corrupted retirement: sticky flag and count of one
    flip_pending = 1'b1;
    step(enc_i(7'h13, 3'd0, 5'd11, 5'd0, 12'd3));
    pad(5);
    for (int i = 13; i < 18; i++) step(enc_i(7'h13, 3'd0, 5'(i), 5'd0, 12'(i)));
    pad(5);
    chk("mism_sticky", mismatch, 1'b1);
    chk("mism_cnt_one", mismatch_cnt, 16'd1);

    // Mid-stream reset with writebacks in flight
    step(enc_s(3'd2, 5'd0, 5'd17, 12'd20));
    for (int i = 1; i < 4; i++) step(enc_i(7'h13, 3'd0, 5'(i), 5'd0, 12'h7FF));
    do_reset();
    pad(6);
    step(enc_i(7'h03, 3'd2, 5'd13, 5'd0, 12'd20));
    step(enc_i(7'h03, 3'd2, 5'd14, 5'd0, 12'd60));
    step(enc_i(7'h03, 3'd2, 5'd15, 5'd0, 12'd68));
    pad(5);
    chk("post_rst_w5", dut_last[13], 32'h55555555);
    chk("post_rst_w15", dut_last[14], 32'hFFFFFFFF);
    chk("load_wrap_w1", dut_last[15], 32'h11111111);

    // Randomized stream against the reference model
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3) begin
        ins = enc_i(7'h13, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 12'($urandom));
      end else if (sel <= 6) begin
        ins = enc_i(7'h03, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 12'($urandom_range(0, 127)));
      end else if (sel <= 8) begin
        ins = enc_s(3'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 12'($urandom_range(0, 127)));
      end else begin
        ins = $urandom;
      end
      step(ins);
    end
    pad(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
